lsu_subword: RTL

Load/store access stage sitting directly upstream of the word-addressed data memory. It accepts byte, halfword and word loads/stores from the execute stage and drives the memory's address, write-data and write-enable inputs. Sub-word stores are performed as a two-cycle read-modify-write with a registered read word, so no combinational read→merge→write path exists. Load data is extracted, sign/zero-extended and returned registered, one cycle after acceptance.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_subword_if.sv | 45 ++++
 rtl/lsu_lane.sv | 73 +++++++
 rtl/lsu_subword.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared encodings for the sub-word load/store stage:
//   DATA_W              - data path width (lane logic assumes 4 byte lanes)
//   size_e              - request size encoding (SZ_BYTE/SZ_HALF/SZ_WORD;
//                         the fourth code behaves as a word)
//   state_e             - access FSM states (ST_IDLE/ST_MERGE)
//   is_misaligned()     - alignment test used when misalignment trapping
//                         (LSU_MISALIGN_TRAP_EN) is compiled in
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    // size[1] set means word access (the illegal code falls in here too).
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (size[1])
            mis = (lo != 2'b00);
        else if (size == SZ_HALF)
            mis = lo[0];
        return mis;
    endfunction

endpackage

// File: rtl/lsu_subword_if.sv
// ---------------------------------------------------------------------------
// lsu_subword_if
// Bundles the execute-side request/response signals and the data-memory
// port of the load/store stage.
//   slave  modport : the LSU (consumes requests, drives memory address/data)
//   master modport : the environment (execute stage plus memory model)
// Signals:
//   req_valid/req_we/req_size/req_signed/req_addr/req_wdata  request
//   busy, load_data, load_valid, err                         response
//   mem_pos, mem_wdata, mem_wr, mem_rdata                    memory port
// ---------------------------------------------------------------------------
interface lsu_subword_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              busy;
    logic [31:0]       load_data;
    logic              load_valid;
    logic              err;

    logic [ADDR_W-1:0] mem_pos;
    logic [31:0]       mem_wdata;
    logic              mem_wr;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output busy, load_data, load_valid, err,
        output mem_pos, mem_wdata, mem_wr
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  busy, load_data, load_valid, err,
        input  mem_pos, mem_wdata, mem_wr
    );
endinterface

// File: rtl/lsu_lane.sv
// ---------------------------------------------------------------------------
// lsu_lane
// Purely combinational big-endian byte-lane logic.
//   merge:   merge_word_i with the lane(s) chosen by merge_addr_i/merge_size_i
//            replaced by right-justified merge_data_i  -> merge_word_o
//   extract: lane(s) of ext_word_i chosen by ext_addr_i/ext_size_i,
//            sign- or zero-extended per ext_signed_i   -> ext_data_o
// Lane 0 is bits [31:24]; lane 3 is bits [7:0]. Halfword uses addr[1] only,
// word ignores both low address bits.
// ---------------------------------------------------------------------------
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] merge_word_i,
    input  logic [31:0] merge_data_i,
    input  logic [1:0]  merge_addr_i,
    input  logic [1:0]  merge_size_i,
    output logic [31:0] merge_word_o,

    input  logic [31:0] ext_word_i,
    input  logic [1:0]  ext_addr_i,
    input  logic [1:0]  ext_size_i,
    input  logic        ext_signed_i,
    output logic [31:0] ext_data_o
);

    logic [7:0] ext_lane [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam int          HI   = 31 - 8 * gi;
        localparam logic [1:0]  LANE = 2'(gi);

        logic       hit;
        logic [7:0] src;

        always_comb begin
            hit = 1'b0;
            src = merge_data_i[7:0];
            case (merge_size_i)
                SZ_BYTE: begin
                    hit = (merge_addr_i == LANE);
                    src = merge_data_i[7:0];
                end
                SZ_HALF: begin
                    hit = (merge_addr_i[1] == LANE[1]);
                    // Upper lane of the half takes data[15:8], lower lane data[7:0].
                    src = LANE[0] ? merge_data_i[7:0] : merge_data_i[15:8];
                end
                default: begin
                    hit = 1'b1;
                    src = merge_data_i[HI -: 8];
                end
            endcase
        end

        assign merge_word_o[HI -: 8] = hit ? src : merge_word_i[HI -: 8];
        assign ext_lane[gi]          = ext_word_i[HI -: 8];
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b          = ext_lane[ext_addr_i];
        h          = ext_addr_i[1] ? ext_word_i[15:0] : ext_word_i[31:16];
        ext_data_o = ext_word_i;
        case (ext_size_i)
            SZ_BYTE: ext_data_o = {{24{ext_signed_i & b[7]}}, b};
            SZ_HALF: ext_data_o = {{16{ext_signed_i & h[15]}}, h};
            default: ext_data_o = ext_word_i;
        endcase
    end

endmodule

// File: rtl/lsu_subword.sv
// ---------------------------------------------------------------------------
// lsu_subword
// Load/store access stage in front of a word-addressed data memory.
// Loads return extended data one cycle after acceptance; word stores write
// in the accepting cycle; byte/halfword stores do a two-cycle
// read-modify-write using a registered copy of the read word, so the memory
// read never feeds the write data combinationally.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - lsu_subword_if.slave (request, response and memory port)
// Build option:
//   LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word requests are
//                          dropped and err pulses the following cycle;
//                          otherwise low address bits are simply ignored
//                          and err is tied low.
// ---------------------------------------------------------------------------
module lsu_subword #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    lsu_subword_if.slave  bus
);
    import lsu_pkg::state_e;
    import lsu_pkg::ST_IDLE;
    import lsu_pkg::ST_MERGE;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] load_data_q;
    logic              load_valid_q;

    logic              accept;
    logic              perform;
    logic              store_word;
    logic              store_sub;
    logic              do_load;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] extracted;

    assign accept = (state_q == ST_IDLE) && bus.req_valid && !rst;

`ifdef LSU_MISALIGN_TRAP_EN
    import lsu_pkg::is_misaligned;

    logic misalign;
    logic err_q;

    assign misalign = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign perform  = accept && !misalign;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= accept && misalign;
    end

    assign bus.err = err_q;
`else
    assign perform = accept;
    assign bus.err = 1'b0;
`endif

    // req_size[1] covers both the word code and the illegal code.
    assign store_word = perform &&  bus.req_we &&  bus.req_size[1];
    assign store_sub  = perform &&  bus.req_we && !bus.req_size[1];
    assign do_load    = perform && !bus.req_we;

    lsu_lane u_lane (
        .merge_word_i (rd_q),
        .merge_data_i (wdata_q),
        .merge_addr_i (addr_q[1:0]),
        .merge_size_i (size_q),
        .merge_word_o (merged_word),
        .ext_word_i   (bus.mem_rdata),
        .ext_addr_i   (bus.req_addr[1:0]),
        .ext_size_i   (bus.req_size),
        .ext_signed_i (bus.req_signed),
        .ext_data_o   (extracted)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (store_sub) state_d = ST_MERGE;
            ST_MERGE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    logic              busy_c;
    logic [ADDR_W-1:0] mem_pos_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              mem_wr_c;

    always_comb begin
        busy_c      = 1'b0;
        mem_pos_c   = bus.req_addr;
        mem_wdata_c = bus.req_wdata;
        mem_wr_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_wr_c = store_word;
            end
            ST_MERGE: begin
                busy_c      = 1'b1;
                mem_pos_c   = addr_q;
                mem_wdata_c = merged_word;
                // A reset landing on the merge cycle cancels the write.
                mem_wr_c    = !rst;
            end
            default: ;
        endcase
    end

    assign bus.busy      = busy_c;
    assign bus.mem_pos   = mem_pos_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.mem_wr    = mem_wr_c;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
        end else begin
            load_valid_q <= do_load;
            if (do_load)
                load_data_q <= extracted;
            if (store_sub) begin
                rd_q    <= bus.mem_rdata;
                addr_q  <= bus.req_addr;
                size_q  <= bus.req_size;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    assign bus.load_data  = load_data_q;
    assign bus.load_valid = load_valid_q;

endmodule
